psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
Shares the single PSRAM controller between two requesters: the CPU bus port and a video line-fetch port, which is read-only. The arbiter is a 4-state sequencer. It arbitrates, issues one strobe to the PSRAM controller, and waits for done or timeout. It then returns data and a one-cycle ack to the owner. It sits between the bus decode / video fetch logic and the psram controller, in the pix_clk domain.

Parameters:
VID_PRIORITY, 1, 1 = video wins ties subject to the starvation limit; 0 = strict round-robin
STARVE_MAX, 4, maximum consecutive video grants while the CPU is pending before the CPU is forced
TIMEOUT_CYCLES, 255, WAIT cycles before abort; the counter is 8 bits wide

Ports:
i_clk  in  1  clock, single domain
i_rst  in  1  synchronous, active-high reset
i_cpu_req  in  1  CPU request, level, held until ack
i_cpu_we  in  1  CPU write enable
i_cpu_addr  in  24  CPU address
i_cpu_din  in  16  CPU write data
o_cpu_ack  out  1  one-cycle completion pulse
o_cpu_dout  out  16  CPU read data, valid with ack
i_vid_req  in  1  video read request, level, held until ack
i_vid_addr  in  24  video address
o_vid_ack  out  1  one-cycle completion pulse
o_vid_dout  out  16  video read data, valid with ack
o_ps_stb  out  1  one-cycle command strobe to PSRAM
o_ps_we  out  1  latched write enable
o_ps_addr  out  24  latched address
o_ps_din  out  16  latched write data
i_ps_busy  in  1  PSRAM controller busy
i_ps_done  in  1  PSRAM transfer complete, one cycle
i_ps_dout  in  16  PSRAM read data, valid with done
o_owner  out  1  current/last owner: 0 = CPU, 1 = video
o_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE.
  - All acks, o_ps_stb, o_ps_we and o_timeout = 0.
  - All addresses and data outputs = 0.
  - o_owner = 0; starvation counter = 0; round-robin pointer = CPU.
  - Reset mid-transaction aborts with no ack. A late i_ps_done is ignored in IDLE.
- IDLE:
  - Arbitration happens only when i_ps_busy = 0 and at least one request is high.
  - Single requester: that requester wins.
  - Both requesters, VID_PRIORITY = 1: video wins unless the starvation counter == STARVE_MAX, in which case the CPU wins.
  - Both requesters, VID_PRIORITY = 0: the pointer holder wins, and the pointer then flips to the other requester.
  - Starvation counter: increments on a video grant while i_cpu_req = 1. It clears on any CPU grant, and also clears whenever i_cpu_req = 0 in IDLE.
  - On a grant:
    - Latch addr, we and din into o_ps_*. Video always gives we = 0 and din = 0.
    - Set o_owner; go to ISSUE.
- ISSUE: o_ps_stb = 1 for exactly this cycle; the timeout counter clears; go to WAIT.
- WAIT:
  - On i_ps_done: latch i_ps_dout into the owner's dout register; go to RESPOND.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES, the owner's dout = 16'h0000, o_timeout pulses in the RESPOND cycle, and the state goes to RESPOND.
  - Done takes precedence over timeout in the same cycle.
- RESPOND:
  - The owner's ack = 1 for one cycle; the other ack stays 0; go to IDLE.
  - The requester must drop its req by the edge that ends the ack cycle. A req still high in IDLE is treated as a new request.
- Latency from req sampled in IDLE (cycle 0): stb at cycle 1. If done arrives at cycle k ≥ 2, ack is at k+1. Minimum latency is 3 cycles; the turnaround back to IDLE adds 1 cycle.
- dout registers hold their value until the next completion for the same port. o_ps_addr/we/din hold until the next grant.
- Requests that change while not in IDLE are ignored.
- Edge cases:
  - i_ps_busy high in IDLE: no grant.
  - i_ps_done outside WAIT: ignored.

Test Plan:
- Reset, then CPU read addr 0x000123; PSRAM returns 16'hBEEF with done 4 cycles after stb. Required: stb at cycle 1, o_cpu_ack at cycle 6, o_cpu_dout = BEEF, o_vid_ack never 1.
- CPU write addr 0x7FFFFE, din 16'h55AA. Required: o_ps_we = 1, o_ps_din = 55AA, o_ps_addr = 7FFFFE during stb; ack after done.
- Both requests held continuously, VID_PRIORITY = 1, STARVE_MAX = 4. Required grant order: V, V, V, V, C, V, V, V, V, C.
- Same stimulus, VID_PRIORITY = 0. Required: strict C, V, C, V alternation starting with C.
- Video read with done never asserted. Required: after 255 WAIT cycles, o_timeout and o_vid_ack pulse together, o_vid_dout = 0, state returns to IDLE.
- Assert i_rst during WAIT, then pulse done after reset. Required: no ack, o_ps_stb = 0, no new grant until a req is present; i_ps_busy high blocks the grant.

Source files
------------

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of the PSRAM controller: CPU read/write and video read-only.
// One command per grant; the owner gets data plus a one-cycle ack on done or timeout.
module psram_arbiter #(
    parameter int VID_PRIORITY   = 1,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [23:0] i_cpu_addr,
    input  logic [15:0] i_cpu_din,
    output logic        o_cpu_ack,
    output logic [15:0] o_cpu_dout,
    input  logic        i_vid_req,
    input  logic [23:0] i_vid_addr,
    output logic        o_vid_ack,
    output logic [15:0] o_vid_dout,
    output logic        o_ps_stb,
    output logic        o_ps_we,
    output logic [23:0] o_ps_addr,
    output logic [15:0] o_ps_din,
    input  logic        i_ps_busy,
    input  logic        i_ps_done,
    input  logic [15:0] i_ps_dout,
    output logic        o_owner,
    output logic        o_timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [1:0]    state;
    logic [7:0]    wait_cnt;
    logic [SW-1:0] starve_cnt;
    logic          rr_vid;
    logic          grant_any;
    logic          grant_vid;

    // Arbitration decision, only acted upon in IDLE
    always_comb begin
        grant_any = 1'b0;
        grant_vid = 1'b0;
        if (!i_ps_busy && (i_cpu_req || i_vid_req)) begin
            grant_any = 1'b1;
            if (i_cpu_req && i_vid_req) begin
                if (VID_PRIORITY != 0)
                    grant_vid = (starve_cnt != SW'(STARVE_MAX));
                else
                    grant_vid = rr_vid;
            end else begin
                grant_vid = i_vid_req;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            starve_cnt <= '0;
            rr_vid     <= 1'b0;
            o_cpu_ack  <= 1'b0;
            o_vid_ack  <= 1'b0;
            o_cpu_dout <= 16'h0000;
            o_vid_dout <= 16'h0000;
            o_ps_stb   <= 1'b0;
            o_ps_we    <= 1'b0;
            o_ps_addr  <= 24'h000000;
            o_ps_din   <= 16'h0000;
            o_owner    <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_ps_stb  <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_vid_ack <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!i_cpu_req)
                        starve_cnt <= '0;
                    if (grant_any) begin
                        o_owner   <= grant_vid;
                        o_ps_addr <= grant_vid ? i_vid_addr : i_cpu_addr;
                        o_ps_we   <= !grant_vid && i_cpu_we;
                        o_ps_din  <= grant_vid ? 16'h0000 : i_cpu_din;
                        o_ps_stb  <= 1'b1;
                        state     <= S_ISSUE;
                        if (!grant_vid)
                            starve_cnt <= '0;
                        else if (i_cpu_req && starve_cnt < SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                        if (i_cpu_req && i_vid_req)
                            rr_vid <= !grant_vid;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Acks are registered here so they are high during RESPOND
                    if (i_ps_done) begin
                        if (o_owner) begin
                            o_vid_dout <= i_ps_dout;
                            o_vid_ack  <= 1'b1;
                        end else begin
                            o_cpu_dout <= i_ps_dout;
                            o_cpu_ack  <= 1'b1;
                        end
                        state <= S_RESPOND;
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        if (o_owner) begin
                            o_vid_dout <= 16'h0000;
                            o_vid_ack  <= 1'b1;
                        end else begin
                            o_cpu_dout <= 16'h0000;
                            o_cpu_ack  <= 1'b1;
                        end
                        o_timeout <= 1'b1;
                        wait_cnt  <= wait_cnt + 8'd1;
                        state     <= S_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: a priority instance and a round-robin instance share stimulus.
module tb_psram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        ps_busy;
    logic        ps_done;
    logic [15:0] ps_dout;

    logic        cpu_ack, vid_ack, ps_stb, ps_we, owner, tmo;
    logic [15:0] cpu_dout, vid_dout, ps_din;
    logic [23:0] ps_addr;

    logic        rr_cpu_ack, rr_vid_ack, rr_stb, rr_we, rr_owner, rr_tmo;
    logic [15:0] rr_cpu_dout, rr_vid_dout, rr_din;
    logic [23:0] rr_addr;

    int checks = 0;
    int errors = 0;

    psram_arbiter #(.VID_PRIORITY(1), .STARVE_MAX(4), .TIMEOUT_CYCLES(255)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
        .o_cpu_ack(cpu_ack), .o_cpu_dout(cpu_dout),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr),
        .o_vid_ack(vid_ack), .o_vid_dout(vid_dout),
        .o_ps_stb(ps_stb), .o_ps_we(ps_we), .o_ps_addr(ps_addr), .o_ps_din(ps_din),
        .i_ps_busy(ps_busy), .i_ps_done(ps_done), .i_ps_dout(ps_dout),
        .o_owner(owner), .o_timeout(tmo)
    );

    psram_arbiter #(.VID_PRIORITY(0), .STARVE_MAX(4), .TIMEOUT_CYCLES(255)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
        .o_cpu_ack(rr_cpu_ack), .o_cpu_dout(rr_cpu_dout),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr),
        .o_vid_ack(rr_vid_ack), .o_vid_dout(rr_vid_dout),
        .o_ps_stb(rr_stb), .o_ps_we(rr_we), .o_ps_addr(rr_addr), .o_ps_din(rr_din),
        .i_ps_busy(ps_busy), .i_ps_done(ps_done), .i_ps_dout(ps_dout),
        .o_owner(rr_owner), .o_timeout(rr_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the strobe, then returns done after dly cycles; leaves us in the ack cycle.
    task automatic xact(input int dly, input logic [15:0] rdata,
                        output logic own, output logic own_rr);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (ps_stb) break;
        end
        chk("stb_latency", n, 1);
        chk("rr_stb_aligned", rr_stb, 1'b1);
        own    = owner;
        own_rr = rr_owner;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (i == 0) chk("stb_one_cycle", ps_stb, 1'b0);
        end
        ps_done = 1'b1;
        ps_dout = rdata;
        tick();
        ps_done = 1'b0;
    endtask

    logic own, own_rr;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        vid_req = 1'b0; vid_addr = '0; ps_busy = 1'b0; ps_done = 1'b0; ps_dout = '0;
        tick(); tick();

        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_vid_ack", vid_ack, 1'b0);
        chk("rst_stb", ps_stb, 1'b0);
        chk("rst_we", ps_we, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_addr", ps_addr, 24'h0);
        chk("rst_dout", {cpu_dout, vid_dout}, 32'h0);
        rst = 1'b0;
        tick();

        // CPU read, done four cycles after the strobe
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000123; cpu_din = 16'h1111;
        xact(4, 16'hBEEF, own, own_rr);
        chk("rd_owner", own, 1'b0);
        chk("rd_addr", ps_addr, 24'h000123);
        chk("rd_we", ps_we, 1'b0);
        chk("rd_cpu_ack", cpu_ack, 1'b1);
        chk("rd_vid_ack", vid_ack, 1'b0);
        chk("rd_cpu_dout", cpu_dout, 16'hBEEF);
        cpu_req = 1'b0;
        tick();
        chk("rd_ack_pulse", cpu_ack, 1'b0);

        // CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h7FFFFE; cpu_din = 16'h55AA;
        xact(2, 16'h0000, own, own_rr);
        chk("wr_owner", own, 1'b0);
        chk("wr_we", ps_we, 1'b1);
        chk("wr_din", ps_din, 16'h55AA);
        chk("wr_addr", ps_addr, 24'h7FFFFE);
        chk("wr_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        // Both held: priority instance V,V,V,V,C repeating; round-robin instance C,V,...
        cpu_req = 1'b1; vid_req = 1'b1; cpu_addr = 24'h000200; vid_addr = 24'h100400;
        for (int i = 0; i < 10; i++) begin
            xact(1, 16'hA000 + 16'(i), own, own_rr);
            chk("prio_owner", own, (i % 5 != 4) ? 1'b1 : 1'b0);
            chk("rr_owner", own_rr, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("prio_ack", own ? vid_ack : cpu_ack, 1'b1);
            chk("prio_other_ack", own ? cpu_ack : vid_ack, 1'b0);
            chk("rr_ack", own_rr ? rr_vid_ack : rr_cpu_ack, 1'b1);
            tick();
        end
        chk("prio_vid_dout", vid_dout, 16'hA008);
        chk("prio_cpu_dout", cpu_dout, 16'hA009);
        cpu_req = 1'b0; vid_req = 1'b0;
        tick(); tick(); tick(); tick();

        // Video read that never completes
        vid_req = 1'b1; vid_addr = 24'hABCDE0;
        tick();
        chk("to_stb", ps_stb, 1'b1);
        chk("to_owner", owner, 1'b1);
        chk("to_we", ps_we, 1'b0);
        chk("to_din", ps_din, 16'h0);
        chk("to_addr", ps_addr, 24'hABCDE0);
        for (int i = 0; i < 255; i++) tick();
        chk("to_early_tmo", tmo, 1'b0);
        chk("to_early_ack", vid_ack, 1'b0);
        tick();
        chk("to_tmo", tmo, 1'b1);
        chk("to_vid_ack", vid_ack, 1'b1);
        chk("to_cpu_ack", cpu_ack, 1'b0);
        chk("to_vid_dout", vid_dout, 16'h0000);
        vid_req = 1'b0;
        tick();
        chk("to_tmo_pulse", tmo, 1'b0);
        chk("to_ack_pulse", vid_ack, 1'b0);

        // Reset in WAIT, then a late done
        cpu_req = 1'b1; cpu_addr = 24'h000456;
        tick();
        chk("rw_stb", ps_stb, 1'b1);
        tick(); tick();
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        rst = 1'b0; ps_done = 1'b1; ps_dout = 16'hDEAD;
        tick();
        ps_done = 1'b0;
        chk("rw_no_ack", {cpu_ack, vid_ack}, 2'b00);
        chk("rw_no_stb", ps_stb, 1'b0);
        chk("rw_addr_clr", ps_addr, 24'h0);
        tick();
        chk("rw_idle_stb", ps_stb, 1'b0);
        chk("rw_dout_kept", cpu_dout, 16'h0000);

        // Busy blocks the grant
        ps_busy = 1'b1; cpu_req = 1'b1; cpu_addr = 24'h000789;
        tick();
        chk("busy_stb0", ps_stb, 1'b0);
        tick();
        chk("busy_stb1", ps_stb, 1'b0);
        ps_busy = 1'b0;
        xact(1, 16'h1234, own, own_rr);
        chk("busy_owner", own, 1'b0);
        chk("busy_addr", ps_addr, 24'h000789);
        chk("busy_ack", cpu_ack, 1'b1);
        chk("busy_dout", cpu_dout, 16'h1234);
        cpu_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
